// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the I/D line-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned LINE_ADDR_W = 28;
  localparam int unsigned LINE_W      = 128;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    GAP
  } arb_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I and D miss ports.
// Only meaningful when at least one side is pending.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned D_PRIORITY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       i_i_pend,
  input  logic       i_d_pend,
  input  logic       i_last_grant,
  input  logic [3:0] i_starve_cnt,
  output logic       o_side
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Pick the side to grant; 1 selects D, 0 selects I.
  always_comb begin
    o_side = SIDE_D;
    if (D_PRIORITY != 0) begin
      // D wins unless I is alone or has waited through LIMIT D grants.
      if (i_i_pend && (!i_d_pend || (i_starve_cnt == LIMIT))) begin
        o_side = SIDE_I;
      end
    end else begin
      if (i_i_pend && i_d_pend) begin
        o_side = ~i_last_grant;
      end else if (i_i_pend) begin
        o_side = SIDE_I;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one slow line memory between the I-cache and D-cache miss ports.
// One transaction at a time: IDLE -> GNT_x -> GAP -> IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = LINE_ADDR_W,
  parameter int unsigned DATA_W       = LINE_W,
  parameter int unsigned D_PRIORITY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e        r_state, w_state_next;
  side_e             r_last_grant, w_last_grant_next;
  logic [3:0]        r_starve_cnt, w_starve_cnt_next;
  logic              r_mem_read, w_mem_read_next;
  logic              r_mem_write, w_mem_write_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;

  logic w_i_pend;
  logic w_d_pend;
  logic w_pick;

  assign w_i_pend = i_read | i_write;
  assign w_d_pend = d_read | d_write;

  mem_arb_pick #(
    .D_PRIORITY  (D_PRIORITY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_i_pend    (w_i_pend),
    .i_d_pend    (w_d_pend),
    .i_last_grant(r_last_grant),
    .i_starve_cnt(r_starve_cnt),
    .o_side      (w_pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: grant from IDLE, leave a grant on mem_ready, always pass through GAP.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:         if (w_i_pend || w_d_pend) w_state_next = w_pick ? GNT_D : GNT_I;
      GNT_I, GNT_D: if (mem_ready) w_state_next = GAP;
      GAP:          w_state_next = IDLE;
      default:      w_state_next = IDLE;
    endcase
  end

  // Next values for the memory-side registers, last grant and starvation count.
  always_comb begin
    w_mem_read_next   = r_mem_read;
    w_mem_write_next  = r_mem_write;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_last_grant_next = r_last_grant;
    w_starve_cnt_next = r_starve_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_i_pend || w_d_pend) begin
          if (w_pick) begin
            // write dominates when a requester raises both strobes
            w_mem_write_next = d_write;
            w_mem_read_next  = d_read & ~d_write;
            w_mem_addr_next  = d_addr;
            w_mem_wdata_next = d_wdata;
            if (D_PRIORITY != 0) begin
              if (!w_i_pend) w_starve_cnt_next = '0;
              else if (r_starve_cnt != LIMIT) w_starve_cnt_next = r_starve_cnt + 4'd1;
            end
          end else begin
            w_mem_write_next  = i_write;
            w_mem_read_next   = i_read & ~i_write;
            w_mem_addr_next   = i_addr;
            w_mem_wdata_next  = i_wdata;
            w_starve_cnt_next = '0;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          w_mem_read_next   = 1'b0;
          w_mem_write_next  = 1'b0;
          w_last_grant_next = (r_state == GNT_D) ? SIDE_D : SIDE_I;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_last_grant <= SIDE_I;
      r_starve_cnt <= '0;
    end else begin
      r_mem_read   <= w_mem_read_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_last_grant <= w_last_grant_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  // Outputs: registered memory strobes, broadcast read data, state-gated ready.
  always_comb begin
    mem_read  = r_mem_read;
    mem_write = r_mem_write;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    i_ready   = (r_state == GNT_I) && mem_ready;
    d_ready   = (r_state == GNT_D) && mem_ready;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: instance 0 is D-priority, instance 1 is round-robin.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          i_read   [2];
  logic          i_write  [2];
  logic [AW-1:0] i_addr   [2];
  logic [DW-1:0] i_wdata  [2];
  logic [DW-1:0] i_rdata  [2];
  logic          i_ready  [2];
  logic          d_read   [2];
  logic          d_write  [2];
  logic [AW-1:0] d_addr   [2];
  logic [DW-1:0] d_wdata  [2];
  logic [DW-1:0] d_rdata  [2];
  logic          d_ready  [2];
  logic          mem_read [2];
  logic          mem_write[2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata[2];
  logic [DW-1:0] mem_rdata[2];
  logic          mem_ready[2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    mem_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .D_PRIORITY  ((g == 0) ? 1 : 0),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_read   (i_read[g]),
      .i_write  (i_write[g]),
      .i_addr   (i_addr[g]),
      .i_wdata  (i_wdata[g]),
      .i_rdata  (i_rdata[g]),
      .i_ready  (i_ready[g]),
      .d_read   (d_read[g]),
      .d_write  (d_write[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_ready  (d_ready[g]),
      .mem_read (mem_read[g]),
      .mem_write(mem_write[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .mem_ready(mem_ready[g])
    );
  end

  typedef struct {
    int            inst;
    bit            side;  // 0 = I, 1 = D
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mem_lat [2];

  function automatic logic [DW-1:0] line_of(logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(int k, bit side, bit wr, logic [AW-1:0] a, logic [DW-1:0] w);
    exp_t e;
    e.inst = k; e.side = side; e.wr = wr; e.addr = a; e.wdata = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(int k, output bit side);
    bit ok;
    ok   = 1'b0;
    side = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (i_ready[k] || d_ready[k]) begin
        side = d_ready[k];
        ok   = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout inst %0d: got no ready, required one", k);
    end
  endtask

  task automatic wait_mem(int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (mem_read[k] || mem_write[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL mem_req_timeout inst %0d: got no mem request, required one", k);
    end
  endtask

  // Slow memory model: ready pulse once the strobe has been seen mem_lat cycles.
  initial begin
    int cnt[2];
    cnt = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      mem_ready[k] = 1'b0;
      mem_rdata[k] = '0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        mem_ready[k] = 1'b0;
        if (!rst_n) begin
          cnt[k] = 0;
        end else if (mem_read[k] || mem_write[k]) begin
          cnt[k]++;
          if (cnt[k] >= mem_lat[k]) begin
            mem_ready[k] = 1'b1;
            mem_rdata[k] = line_of(mem_addr[k]);
            cnt[k]       = 0;
          end
        end else begin
          cnt[k] = 0;
        end
      end
    end
  end

  // Monitor: every ready pulse is matched against the next expected transaction,
  // and the two cycles after it must show an idle memory bus.
  initial begin
    int   gap[2];
    exp_t e;
    gap = '{0, 0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          gap[k] = 0;
        end else begin
          if (gap[k] > 0) begin
            chk("gap_idle", 128'({mem_read[k], mem_write[k]}), 128'(0));
            gap[k]--;
          end
          if (i_ready[k] || d_ready[k]) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_ready inst %0d: got ready i=%0b d=%0b, required none",
                       k, i_ready[k], d_ready[k]);
            end else begin
              e = exp_q.pop_front();
              chk("ready_inst", 128'(k), 128'(e.inst));
              chk("ready_side", 128'({i_ready[k], d_ready[k]}), e.side ? 128'(1) : 128'(2));
              chk("mem_op", 128'({mem_read[k], mem_write[k]}), e.wr ? 128'(1) : 128'(2));
              chk("mem_addr", 128'(mem_addr[k]), 128'(e.addr));
              if (e.wr) chk("mem_wdata", mem_wdata[k], e.wdata);
              else      chk("rdata", e.side ? d_rdata[k] : i_rdata[k], line_of(e.addr));
              gap[k] = 2;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit side;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0; i_write[k] = 0; i_addr[k] = '0; i_wdata[k] = '0;
      d_read[k] = 0; d_write[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    mem_lat = '{5, 3};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_read",  128'(mem_read[k]),  128'(0));
      chk("rst_mem_write", 128'(mem_write[k]), 128'(0));
      chk("rst_mem_addr",  128'(mem_addr[k]),  128'(0));
      chk("rst_mem_wdata", mem_wdata[k],       128'(0));
      chk("rst_i_ready",   128'(i_ready[k]),   128'(0));
      chk("rst_d_ready",   128'(d_ready[k]),   128'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #2;

    // T1: lone I read with 1-cycle arbitration latency
    push(0, 0, 0, 28'h0000010, '0);
    i_read[0] = 1; i_addr[0] = 28'h0000010;
    chk("t1_pre_mem_read", 128'(mem_read[0]), 128'(0));
    @(posedge clk); #2;
    chk("t1_mem_read", 128'(mem_read[0]), 128'(1));
    chk("t1_mem_addr", 128'(mem_addr[0]), 128'(28'h0000010));
    wait_ready(0, side);
    chk("t1_side", 128'(side), 128'(0));
    i_read[0] = 0;
    repeat (3) @(posedge clk);
    #2;

    // T2: simultaneous I read and D write, D first, I granted 2 cycles after d_ready
    push(0, 1, 1, 28'h0002000, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
    push(0, 0, 0, 28'h0000030, '0);
    d_write[0] = 1; d_addr[0] = 28'h0002000; d_wdata[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    i_read[0]  = 1; i_addr[0] = 28'h0000030;
    wait_ready(0, side);
    chk("t2_first_side", 128'(side), 128'(1));
    d_write[0] = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("t2_idle_mem_read", 128'(mem_read[0]), 128'(0));
    @(posedge clk); #2;
    chk("t2_i_grant", 128'(mem_read[0]), 128'(1));
    chk("t2_i_addr", 128'(mem_addr[0]), 128'(28'h0000030));
    wait_ready(0, side);
    chk("t2_second_side", 128'(side), 128'(0));
    i_read[0] = 0;
    repeat (3) @(posedge clk);
    #2;

    // T3: starvation guard, 4 D grants then I, then D again with the count cleared
    for (int j = 0; j < 4; j++) push(0, 1, 0, 28'(32'h100 + j), '0);
    push(0, 0, 0, 28'h0000040, '0);
    push(0, 1, 0, 28'h0000104, '0);
    i_read[0] = 1; i_addr[0] = 28'h0000040;
    d_read[0] = 1; d_addr[0] = 28'h0000100;
    for (int j = 0; j < 4; j++) begin
      wait_ready(0, side);
      chk("t3_d_side", 128'(side), 128'(1));
      d_addr[0] = 28'(32'h101 + j);
    end
    wait_ready(0, side);
    chk("t3_i_side", 128'(side), 128'(0));
    i_read[0] = 0;
    wait_ready(0, side);
    chk("t3_d_after", 128'(side), 128'(1));
    d_read[0] = 0;
    repeat (3) @(posedge clk);
    #2;

    // T4: round-robin, lone D then alternation I,D,I,D
    push(1, 1, 0, 28'h0000200, '0);
    d_read[1] = 1; d_addr[1] = 28'h0000200;
    wait_ready(1, side);
    d_read[1] = 0;
    repeat (3) @(posedge clk);
    #2;
    push(1, 0, 0, 28'h0000300, '0);
    push(1, 1, 0, 28'h0000400, '0);
    push(1, 0, 0, 28'h0000301, '0);
    push(1, 1, 0, 28'h0000401, '0);
    i_read[1] = 1; i_addr[1] = 28'h0000300;
    d_read[1] = 1; d_addr[1] = 28'h0000400;
    for (int j = 0; j < 4; j++) begin
      wait_ready(1, side);
      chk("t4_order", 128'(side), 128'(j % 2));
      if (side == 0) begin
        if (j < 2) i_addr[1] = 28'h0000301; else i_read[1] = 0;
      end else begin
        if (j < 2) d_addr[1] = 28'h0000401; else d_read[1] = 0;
      end
    end
    i_read[1] = 0; d_read[1] = 0;
    repeat (3) @(posedge clk);
    #2;

    // T5: reset two cycles into GNT_D abandons the transaction
    mem_lat[0] = 10;
    d_read[0] = 1; d_addr[0] = 28'h0000500;
    wait_mem(0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mem_read",  128'(mem_read[0]),  128'(0));
    chk("t5_mem_write", 128'(mem_write[0]), 128'(0));
    chk("t5_mem_addr",  128'(mem_addr[0]),  128'(0));
    chk("t5_d_ready",   128'(d_ready[0]),   128'(0));
    d_read[0] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mem_lat[0] = 4;
    @(posedge clk); #2;
    push(0, 1, 0, 28'h0000510, '0);
    d_read[0] = 1; d_addr[0] = 28'h0000510;
    wait_ready(0, side);
    chk("t5_fresh_side", 128'(side), 128'(1));
    d_read[0] = 0;
    repeat (3) @(posedge clk);
    #2;

    // T6: I drops its request right after grant; transaction still completes
    push(0, 0, 0, 28'h0000600, '0);
    i_read[0] = 1; i_addr[0] = 28'h0000600;
    wait_mem(0);
    @(posedge clk); #2;
    i_read[0] = 0;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (i_ready[0]) begin
          got = 1'b1;
          break;
        end
        chk("t6_mem_read_held", 128'(mem_read[0]), 128'(1));
        @(posedge clk); #2;
      end
      chk("t6_i_ready_seen", 128'(got), 128'(1));
    end
    repeat (3) @(posedge clk);
    #2;
    chk("t6_no_regrant", 128'({mem_read[0], mem_write[0]}), 128'(0));

    repeat (5) @(posedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow line memory (128-bit line, 28-bit line address, read/write/ready handshake) between the I-cache and D-cache miss ports inside CHIP.
- Lets a single slow_memory instance replace the separate slow_memI and slow_memD.
- Serialises line fills and write-backs.
- Fixed D priority with a starvation guard, or round-robin.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- DATA_W, 128, line width.
- D_PRIORITY, 1, 1 = D-cache wins ties; 0 = round-robin.
- STARVE_LIMIT, 4, consecutive D grants allowed while I waits (D_PRIORITY=1 only); range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request
- i_write  in  1  I-cache line write request (tied 0 in CHIP, still arbitrated)
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  DATA_W  I-cache write line
- i_rdata  out  DATA_W  read line to I-cache
- i_ready  out  1  I-cache transaction complete
- d_read, d_write, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  D-cache request, same meaning as the I side
- d_rdata  out  DATA_W  read line to D-cache
- d_ready  out  1  D-cache transaction complete
- mem_read  out  1  to slow memory
- mem_write  out  1  to slow memory
- mem_addr  out  ADDR_W  to slow memory
- mem_wdata  out  DATA_W  to slow memory
- mem_rdata  in  DATA_W  from slow memory
- mem_ready  in  1  from slow memory, one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; last_grant=I; starve_cnt=0; i_ready=0, d_ready=0.
- Requester protocol: a requester holds read or write, plus addr/wdata, until its ready pulse, then may drop or re-issue.
  - read and write both high: treated as write.
- States: IDLE, GNT_I, GNT_D, GAP.
- IDLE:
  - Request pending: latch winner's op/addr/wdata into the mem_* output registers; go to GNT_I or GNT_D.
  - mem_read/mem_write assert the cycle after the request is sampled (1-cycle arbitration latency).
  - No request: stay.
- Winner selection:
  - D_PRIORITY=1: D wins unless I is pending and starve_cnt==STARVE_LIMIT, in which case I wins.
  - D_PRIORITY=0: only one pending, that one wins. Both pending, the side opposite last_grant wins.
- GNT_x:
  - Hold mem_* registers constant; x_ready = mem_ready (combinational, gated by state).
  - On mem_ready: drop mem_read/mem_write in the next register update, update last_grant=x, go to GAP.
- GAP:
  - One cycle with mem_read=mem_write=0 so the memory sees a deassert and the requester can retire.
  - Always return to IDLE. No back-to-back grant without GAP.
  - Minimum spacing between grants is 2 cycles after ready.
- starve_cnt:
  - Increments when D is granted while I is pending; saturates at STARVE_LIMIT.
  - Clears to 0 when I is granted or when I is not pending at a D grant.
- Read data routing: i_rdata = d_rdata = mem_rdata (broadcast); only the granted side's ready is ever high. The ungranted ready is constant 0.
- Requester drops its request mid-grant: transaction still completes, ready pulse still emitted, then GAP.
- Simultaneous ready and new requests: new requests are not sampled until IDLE.
- Reset asserted mid-grant: immediate return to reset values; in-flight memory transaction abandoned; no ready pulse.
- Write path: no data returned; x_ready signals write complete.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, GNT_I, GNT_D, GAP}
  - grant-side enum {SIDE_I, SIDE_D}
  - localparam LINE_ADDR_W=28, LINE_W=128
- Sub-module mem_arb_pick: combinational winner selection (pending flags, last_grant, starve_cnt, D_PRIORITY → side).
- All state, counters and mem_* registers live in the top.

Test Plan:
1. Lone I read, addr 0x0000010; memory ready 5 cycles after mem_read → mem_read high 1 cycle after i_read, mem_addr=0x0000010, i_ready single pulse, i_rdata=mem_rdata, d_ready stays 0, mem_read low in GAP.
2. I read and D write issued the same cycle, D_PRIORITY=1 → D served first (mem_write=1, mem_wdata=d_wdata), d_ready, GAP, then I read granted 2 cycles after d_ready.
3. D_PRIORITY=1, STARVE_LIMIT=4; D re-requests continuously, I held high → exactly 4 D grants, then the I grant, then starve_cnt=0.
4. D_PRIORITY=0, both requesting continuously → grants alternate I,D,I,D; last_grant toggles each completion.
5. rst_n pulled low 2 cycles into GNT_D → mem_read/mem_write=0 immediately; no d_ready; after release, a fresh D request is granted normally.
6. I drops i_read 1 cycle after grant → mem_read held until mem_ready, i_ready pulses once, then GAP and IDLE.
